// File: rtl/lap_buffer_57_pkg.sv
// Shared timekeeping constants: default field width and packed {hour,min,sec} record layout.
package lap_buffer_57_pkg;

    localparam int FIELD_W_DEF = 7;
    localparam int DEPTH_DEF   = 8;

    function automatic int rec_w(input int field_w);
        return 3 * field_w;
    endfunction

endpackage

// File: rtl/lap_buffer_57_ptr.sv
// Head/tail/occupancy bookkeeping for the lap buffer, plus full/empty/sticky overflow flags.
module lap_ptr_57
    import lap_buffer_57_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          overwrite_i,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [AW-1:0] head_o,
    output logic [AW-1:0] tail_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          overflow_o,
    output logic          wr_en_o
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          full_q, empty_q;
    logic          wr_en;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (push_i && pop_i && !empty_q) begin
            // Replace-in-place: oldest leaves as newest arrives, occupancy unchanged.
            wr_en  = 1'b1;
            head_d = head_q + PTR_ONE;
            tail_d = tail_q + PTR_ONE;
        end else if (push_i) begin
            if (!full_q) begin
                wr_en   = 1'b1;
                tail_d  = tail_q + PTR_ONE;
                count_d = count_q + CNT_ONE;
            end else if (overwrite_i) begin
                wr_en  = 1'b1;
                head_d = head_q + PTR_ONE;
                tail_d = tail_q + PTR_ONE;
                ovf_d  = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop_i && !empty_q) begin
            head_d  = head_q + PTR_ONE;
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            full_q  <= (count_d == CNT_FULL);
            empty_q <= (count_d == '0);
        end
    end

    assign head_o     = head_q;
    assign tail_o     = tail_q;
    assign count_o    = count_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = ovf_q;
    assign wr_en_o    = wr_en;

endmodule

// File: rtl/lap_buffer_57.sv
// Circular lap/split snapshot store: push/pop of hh:mm:ss records with registered indexed read.
module lap_buffer_57
    import lap_buffer_57_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk_57,
    input  logic               rst_57,
    input  logic               clear_57,
    input  logic               overwrite_57,
    input  logic               push_57,
    input  logic [FIELD_W-1:0] push_sec_57,
    input  logic [FIELD_W-1:0] push_min_57,
    input  logic [FIELD_W-1:0] push_hour_57,
    input  logic               pop_57,
    input  logic               rd_e_57,
    input  logic [AW-1:0]      rd_idx_57,
    output logic [FIELD_W-1:0] rd_sec_57,
    output logic [FIELD_W-1:0] rd_min_57,
    output logic [FIELD_W-1:0] rd_hour_57,
    output logic               rd_valid_57,
    output logic               rd_err_57,
    output logic [AW:0]        count_57,
    output logic               full_57,
    output logic               empty_57,
    output logic               overflow_57
);

    localparam int REC_W = rec_w(FIELD_W);

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [REC_W-1:0] wr_rec;
    logic [REC_W-1:0] rd_rec_q;
    logic             rd_valid_q, rd_err_q;
    logic [AW-1:0]    head, tail, rd_addr;
    logic [AW:0]      count;
    logic             wr_en, rd_in_range;

    lap_ptr_57 #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_ptr (
        .clk_i      (clk_57),
        .rst_i      (rst_57),
        .clear_i    (clear_57),
        .overwrite_i(overwrite_57),
        .push_i     (push_57),
        .pop_i      (pop_57),
        .head_o     (head),
        .tail_o     (tail),
        .count_o    (count),
        .full_o     (full_57),
        .empty_o    (empty_57),
        .overflow_o (overflow_57),
        .wr_en_o    (wr_en)
    );

    assign wr_rec      = {push_hour_57, push_min_57, push_sec_57};
    assign rd_addr     = head + rd_idx_57;
    assign rd_in_range = ({1'b0, rd_idx_57} < count);

    // Storage is deliberately not reset; rd_err keeps unwritten slots from being observed.
    always_ff @(posedge clk_57) begin
        if (wr_en) begin
            mem_q[tail] <= wr_rec;
        end
    end

    // Index is judged against pre-update count/head; same-cycle writes are not visible.
    always_ff @(posedge clk_57 or posedge rst_57) begin
        if (rst_57) begin
            rd_rec_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            if (rd_e_57) begin
                if (clear_57 || !rd_in_range) begin
                    rd_err_q <= 1'b1;
                end else begin
                    rd_rec_q   <= mem_q[rd_addr];
                    rd_valid_q <= 1'b1;
                end
            end
        end
    end

    assign rd_sec_57   = rd_rec_q[FIELD_W-1:0];
    assign rd_min_57   = rd_rec_q[2*FIELD_W-1:FIELD_W];
    assign rd_hour_57  = rd_rec_q[3*FIELD_W-1:2*FIELD_W];
    assign rd_valid_57 = rd_valid_q;
    assign rd_err_57   = rd_err_q;
    assign count_57    = count;

endmodule

// File: tb/tb_lap_buffer_57.sv
// Checks lap_buffer_57 against a queue-based model every cycle, plus directed literal checks.
module tb_lap_buffer_57;

    localparam int DEPTH = 8;
    localparam int FW    = 7;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0, ow = 1'b0, push = 1'b0, pop = 1'b0, rd_e = 1'b0;
    logic [FW-1:0] ps = '0, pm = '0, ph = '0;
    logic [AW-1:0] idx = '0;
    logic [FW-1:0] rd_sec, rd_min, rd_hour;
    logic          rd_valid, rd_err, full, empty, overflow;
    logic [AW:0]   count;

    lap_buffer_57 #(.DEPTH(DEPTH), .FIELD_W(FW)) dut (
        .clk_57      (clk),
        .rst_57      (rst),
        .clear_57    (clear),
        .overwrite_57(ow),
        .push_57     (push),
        .push_sec_57 (ps),
        .push_min_57 (pm),
        .push_hour_57(ph),
        .pop_57      (pop),
        .rd_e_57     (rd_e),
        .rd_idx_57   (idx),
        .rd_sec_57   (rd_sec),
        .rd_min_57   (rd_min),
        .rd_hour_57  (rd_hour),
        .rd_valid_57 (rd_valid),
        .rd_err_57   (rd_err),
        .count_57    (count),
        .full_57     (full),
        .empty_57    (empty),
        .overflow_57 (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int m;
        int h;
    } rec_t;

    rec_t mq[$];
    int   m_s = 0, m_m = 0, m_h = 0;
    bit   m_v = 0, m_e = 0, m_ovf = 0;
    int   n_pass = 0, n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour: an ordered list of records, oldest first.
    task automatic model_step();
        int   n;
        rec_t nr;
        if (rst) begin
            mq.delete();
            m_s = 0; m_m = 0; m_h = 0;
            m_v = 0; m_e = 0; m_ovf = 0;
            return;
        end
        n   = mq.size();
        m_v = 0;
        m_e = 0;
        if (rd_e) begin
            if (clear || int'(idx) >= n) m_e = 1;
            else begin
                m_s = mq[idx].s; m_m = mq[idx].m; m_h = mq[idx].h;
                m_v = 1;
            end
        end
        nr.s = int'(ps); nr.m = int'(pm); nr.h = int'(ph);
        if (clear) begin
            mq.delete();
            m_ovf = 0;
        end else if (push && pop && n > 0) begin
            void'(mq.pop_front());
            mq.push_back(nr);
        end else if (push) begin
            if (n < DEPTH) mq.push_back(nr);
            else begin
                m_ovf = 1;
                if (ow) begin
                    void'(mq.pop_front());
                    mq.push_back(nr);
                end
            end
        end else if (pop && n > 0) begin
            void'(mq.pop_front());
        end
    endtask

    task automatic compare();
        chk("count",    int'(count),    mq.size());
        chk("full",     int'(full),     int'(mq.size() == DEPTH));
        chk("empty",    int'(empty),    int'(mq.size() == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("rd_valid", int'(rd_valid), int'(m_v));
        chk("rd_err",   int'(rd_err),   int'(m_e));
        chk("rd_sec",   int'(rd_sec),   m_s);
        chk("rd_min",   int'(rd_min),   m_m);
        chk("rd_hour",  int'(rd_hour),  m_h);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        clear = 0; push = 0; pop = 0; rd_e = 0;
    endtask

    task automatic do_push(input int s, input int m, input int h);
        push = 1; ps = FW'(s); pm = FW'(m); ph = FW'(h);
        tick();
        push = 0;
    endtask

    task automatic do_read(input int i);
        rd_e = 1; idx = AW'(i);
        tick();
        rd_e = 0;
    endtask

    initial begin
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("lit_reset_count", int'(count), 0);
        chk("lit_reset_empty", int'(empty), 1);
        chk("lit_reset_ovf", int'(overflow), 0);
        do_read(0);
        chk("lit_empty_rd_err", int'(rd_err), 1);
        chk("lit_empty_rd_valid", int'(rd_valid), 0);
        tick();
        chk("lit_rd_err_pulse", int'(rd_err), 0);

        ow = 0;
        do_push(5, 0, 0);
        do_push(10, 1, 0);
        do_push(3, 2, 1);
        chk("lit_count3", int'(count), 3);
        rd_e = 1; idx = 0; tick();
        chk("lit_rd0_valid", int'(rd_valid), 1);
        chk("lit_rd0_sec", int'(rd_sec), 5);
        idx = 1; tick();
        chk("lit_rd1_valid", int'(rd_valid), 1);
        chk("lit_rd1_min", int'(rd_min), 1);
        chk("lit_rd1_sec", int'(rd_sec), 10);
        idx = 2; tick();
        chk("lit_rd2_hour", int'(rd_hour), 1);
        chk("lit_rd2_min", int'(rd_min), 2);
        chk("lit_rd2_sec", int'(rd_sec), 3);
        rd_e = 0;

        clear = 1; tick(); clear = 0;
        ow = 1;
        for (int i = 1; i <= 10; i++) do_push(i, 0, 0);
        chk("lit_ow_count", int'(count), 8);
        chk("lit_ow_full", int'(full), 1);
        chk("lit_ow_ovf", int'(overflow), 1);
        do_read(0);
        chk("lit_ow_oldest", int'(rd_sec), 3);
        do_read(7);
        chk("lit_ow_newest", int'(rd_sec), 10);

        clear = 1; tick(); clear = 0;
        chk("lit_clear_ovf", int'(overflow), 0);
        ow = 0;
        for (int i = 1; i <= 8; i++) do_push(i, 0, 0);
        chk("lit_fill_ovf", int'(overflow), 0);
        do_push(99, 0, 0);
        chk("lit_drop_ovf", int'(overflow), 1);
        chk("lit_drop_count", int'(count), 8);
        do_read(7);
        chk("lit_drop_newest", int'(rd_sec), 8);
        push = 1; pop = 1; ps = 50; pm = 0; ph = 0;
        tick();
        idle();
        chk("lit_pp_count", int'(count), 8);
        chk("lit_pp_ovf", int'(overflow), 1);
        do_read(0);
        chk("lit_pp_oldest", int'(rd_sec), 2);
        do_read(7);
        chk("lit_pp_newest", int'(rd_sec), 50);

        clear = 1; tick(); clear = 0;
        pop = 1; tick(); pop = 0;
        chk("lit_pop_empty_count", int'(count), 0);
        chk("lit_pop_empty_ovf", int'(overflow), 0);
        ow = 1;
        for (int i = 0; i < 9; i++) do_push(20 + i, 3, 4);
        clear = 1; rd_e = 1; idx = 0;
        tick();
        idle();
        chk("lit_clr_count", int'(count), 0);
        chk("lit_clr_ovf", int'(overflow), 0);
        chk("lit_clr_rd_err", int'(rd_err), 1);

        for (int i = 0; i < 9; i++) do_push(30 + i, 5, 6);
        do_read(1);
        chk("lit_pre_rst_sec", int'(rd_sec), 32);
        #2 rst = 1;
        #1;
        chk("lit_arst_count", int'(count), 0);
        chk("lit_arst_empty", int'(empty), 1);
        chk("lit_arst_full", int'(full), 0);
        chk("lit_arst_ovf", int'(overflow), 0);
        chk("lit_arst_rd_sec", int'(rd_sec), 0);
        chk("lit_arst_rd_valid", int'(rd_valid), 0);
        tick();
        rst = 0;
        do_push(42, 7, 9);
        do_read(0);
        chk("lit_post_rst_sec", int'(rd_sec), 42);
        chk("lit_post_rst_hour", int'(rd_hour), 9);

        for (int c = 0; c < 600; c++) begin
            ow    = 1'($urandom_range(0, 1));
            push  = ($urandom_range(0, 99) < 50);
            pop   = ($urandom_range(0, 99) < 35);
            rd_e  = ($urandom_range(0, 99) < 50);
            clear = ($urandom_range(0, 99) < 3);
            idx   = AW'($urandom_range(0, DEPTH - 1));
            ps    = FW'($urandom);
            pm    = FW'($urandom);
            ph    = FW'($urandom);
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
